pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the CPU program counter register and sequences it every instruction: sequential fetch (PC+4), conditional branch (BEQ/BNE), unconditional jump, memory-busy stalls and halt.
- Sits between the control unit, ALU ZERO flag and instruction/data cache BUSYWAIT lines, and the instruction memory address port.
- Captures the control-transfer decision once per instruction so stalls cannot corrupt the target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; first fetch address.
- PC_UPDATE_DELAY, 1, simulation delay in ns from posedge CLK to PC output change.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- BRANCH  in  1  instruction is BEQ.
- BRANCH_NE  in  1  instruction is BNE.
- JUMP  in  1  instruction is J.
- ZERO  in  1  ALU zero flag for the current instruction.
- OFFSET  in  8  signed word offset from the instruction.
- BUSYWAIT  in  1  OR of instruction and data cache busy.
- HALT  in  1  halt request from control unit.
- PC  out  32  current instruction address.
- IREAD  out  1  instruction fetch request.
- STALL_CNT  out  STALL_CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Reset (RESET=0, asynchronous): PC=RESET_VECTOR, IREAD=0, STALL_CNT=0, pending_valid=0, pending_target=0, state=BOOT. Holds while RESET=0.
- States: BOOT, RUN, STALL, HALTED. 2-bit encoding.
- BOOT: exactly one cycle after reset release. IREAD=0, PC held. Next state RUN. Inputs ignored.
- RUN: IREAD=1. Compute seq = PC+4. Compute tgt = seq + (sign_extend_32(OFFSET) << 2), modulo 2^32.
  - taken = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO). next = taken ? tgt : seq.
  - Priority: HALT > BUSYWAIT > normal update.
  - HALT=1: go to HALTED; PC held. BUSYWAIT is ignored.
  - BUSYWAIT=1: go to STALL; PC held; pending_target=next; pending_valid=1.
  - Otherwise: PC <= next, PC_UPDATE_DELAY after the edge; stay in RUN.
- STALL: IREAD=1, PC held. Control inputs, ZERO and OFFSET are ignored (decision already captured).
  - BUSYWAIT=1: stay in STALL; STALL_CNT += 1, saturating at all-ones.
  - BUSYWAIT=0: PC <= pending_target; pending_valid=0; go to RUN.
  - HALT is ignored in STALL. It is sampled again on the next RUN cycle.
- STALL_CNT counts the RUN→STALL entry cycle plus every STALL cycle with BUSYWAIT=1.
- HALTED: IREAD=0; PC frozen. Only RESET exits this state.
- Offset range: -128..+127 words relative to PC+4. Wrap-around at 2^32 is silent, with no flag.
- Illegal state encoding: recover to RUN on the next edge with PC unchanged.
- Reset asserted mid-stall or mid-halt: all state cleared immediately; the pending target is discarded.
- Simultaneous JUMP and BRANCH: JUMP wins, because taken is an OR and the target is identical.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state encodings BOOT=2'd0, RUN=2'd1, STALL=2'd2, HALTED=2'd3;
  - the PC_STEP=4 constant;
  - the WORD_SHIFT=2 constant.
- One combinational sub-module, next_pc_calc. It takes PC, OFFSET, BRANCH, BRANCH_NE, JUMP and ZERO, and produces seq, tgt and next.
- The FSM, PC register, pending latch and counter stay in pc_sequencer.

Test Plan:
- Reset/boot: hold RESET=0 for 3 cycles, then release → PC=0 and IREAD=0 for one cycle; then IREAD=1; PC steps 0→4→8 on consecutive edges.
- Branch taken: PC=0x10, BRANCH=1, ZERO=1, OFFSET=8'hFE → PC=0x0C. Same stimulus with ZERO=0 → PC=0x14.
- BNE/jump: PC=0x20, BRANCH_NE=1, ZERO=0, OFFSET=8'h03 → PC=0x30. PC=0x30, JUMP=1, OFFSET=8'h80 → PC=0x34-0x200=0xFFFF_FE34.
- Stall with captured target:
  - Stimulus: at PC=0x40 set JUMP=1, OFFSET=5 and BUSYWAIT=1 for 4 cycles. During the stall, drop JUMP and set OFFSET=0.
  - Response: PC stays 0x40 throughout, then becomes 0x58; STALL_CNT=4.
- Halt: HALT=1 at PC=0x8 → PC frozen at 0x8 and IREAD=0 indefinitely; BUSYWAIT toggling has no effect. RESET=0 → PC=0.
- Async reset mid-stall: RESET=0 between clock edges during STALL → PC=RESET_VECTOR immediately and STALL_CNT=0. After release, a BOOT cycle follows, then fetch from 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam int          WORD_SHIFT = 2;

  function automatic logic [31:0] word_offset(
    input logic [7:0] off
  );
    logic [31:0] w_ext;
    w_ext = {{24{off[7]}}, off};
    return w_ext << WORD_SHIFT;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: sequential, target and the
// selected next address for one instruction.
module next_pc_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [7:0]  i_offset,
  input  logic        i_branch,
  input  logic        i_branch_ne,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_seq,
  output logic [31:0] o_tgt,
  output logic [31:0] o_next
);

  logic w_taken;

  assign o_seq   = i_pc + PC_STEP;
  assign o_tgt   = o_seq + word_offset(i_offset);
  assign w_taken = i_jump
                 | (i_branch & i_zero)
                 | (i_branch_ne & ~i_zero);
  assign o_next  = w_taken ? o_tgt : o_seq;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: boot, fetch, branch/jump, stall capture
// and halt sequencing.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          PC_UPDATE_DELAY = 1,
  parameter int          STALL_CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   BRANCH,
  input  logic                   BRANCH_NE,
  input  logic                   JUMP,
  input  logic                   ZERO,
  input  logic [7:0]             OFFSET,
  input  logic                   BUSYWAIT,
  input  logic                   HALT,
  output logic [31:0]            PC,
  output logic                   IREAD,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_pc;
  logic [31:0]            w_pc_nxt;
  logic [31:0]            r_pend_tgt;
  logic [31:0]            w_pend_tgt_nxt;
  logic                   r_pend_vld;
  logic                   w_pend_vld_nxt;
  logic [STALL_CNT_W-1:0] r_cnt;
  logic                   w_cnt_inc;
  logic [31:0]            w_seq;
  logic [31:0]            w_tgt;
  logic [31:0]            w_next;
  logic                   w_unused;

  next_pc_calc u_calc (
    .i_pc        (r_pc),
    .i_offset    (OFFSET),
    .i_branch    (BRANCH),
    .i_branch_ne (BRANCH_NE),
    .i_jump      (JUMP),
    .i_zero      (ZERO),
    .o_seq       (w_seq),
    .o_tgt       (w_tgt),
    .o_next      (w_next)
  );

  // Output delay is a sim-only notion; the register updates at the edge.
  assign w_unused = ^{w_seq, w_tgt} ^ (PC_UPDATE_DELAY != 0);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_vld_nxt = r_pend_vld;
    w_cnt_inc      = 1'b0;
    unique case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (HALT) begin
          w_state_nxt = HALTED;
        end else if (BUSYWAIT) begin
          w_state_nxt    = STALL;
          w_pend_tgt_nxt = w_next;
          w_pend_vld_nxt = 1'b1;
          w_cnt_inc      = 1'b1;
        end else begin
          w_pc_nxt = w_next;
        end
      end
      STALL: begin
        if (BUSYWAIT) begin
          w_cnt_inc = 1'b1;
        end else begin
          w_pc_nxt       = r_pend_vld ? r_pend_tgt : r_pc;
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = RUN;
        end
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_pend_tgt <= '0;
      r_pend_vld <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign PC        = r_pc;
  assign IREAD     = (r_state == RUN) || (r_state == STALL);
  assign STALL_CNT = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer.
module tb_pc_sequencer;

  logic        CLK;
  logic        RESET;
  logic        BRANCH;
  logic        BRANCH_NE;
  logic        JUMP;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic        BUSYWAIT;
  logic        HALT;
  logic [31:0] PC;
  logic        IREAD;
  logic [15:0] STALL_CNT;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        br;
    logic        bne;
    logic        jmp;
    logic        zero;
    logic [7:0]  off;
    logic        busy;
    logic        halt;
    logic [31:0] pc;
    logic        iread;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [25];

  pc_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BRANCH    (BRANCH),
    .BRANCH_NE (BRANCH_NE),
    .JUMP      (JUMP),
    .ZERO      (ZERO),
    .OFFSET    (OFFSET),
    .BUSYWAIT  (BUSYWAIT),
    .HALT      (HALT),
    .PC        (PC),
    .IREAD     (IREAD),
    .STALL_CNT (STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(
    input logic br, bne, jmp, zero,
    input logic [7:0] off,
    input logic busy, halt,
    input logic [31:0] pc,
    input logic iread,
    input logic [15:0] cnt
  );
    vec_t v;
    v.br = br; v.bne = bne; v.jmp = jmp; v.zero = zero;
    v.off = off; v.busy = busy; v.halt = halt;
    v.pc = pc; v.iread = iread; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] pc,
                         input logic iread,
                         input logic [15:0] cnt);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".iread"}, {31'd0, IREAD}, {31'd0, iread});
    chk({tag, ".cnt"}, {16'd0, STALL_CNT}, {16'd0, cnt});
  endtask

  task automatic drive(input logic br, bne, jmp, zero,
                       input logic [7:0] off,
                       input logic busy, halt);
    BRANCH = br; BRANCH_NE = bne; JUMP = jmp; ZERO = zero;
    OFFSET = off; BUSYWAIT = busy; HALT = halt;
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    repeat (3) step();
    chk_all("rst", 32'h0, 1'b0, 16'd0);
    RESET = 1'b1;
    #1;
    chk_all("boot", 32'h0, 1'b0, 16'd0);
  endtask

  initial begin
    vt[0]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0000,1,0);
    vt[1]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0004,1,0);
    vt[2]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0008,1,0);
    vt[3]  = mk(0,0,0,0,8'h00,0,0,32'h0000_000C,1,0);
    vt[4]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0010,1,0);
    vt[5]  = mk(1,0,0,1,8'hFE,0,0,32'h0000_000C,1,0);
    vt[6]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0010,1,0);
    vt[7]  = mk(1,0,0,0,8'hFE,0,0,32'h0000_0014,1,0);
    vt[8]  = mk(0,0,1,0,8'h01,0,0,32'h0000_001C,1,0);
    vt[9]  = mk(0,0,0,0,8'h00,0,0,32'h0000_0020,1,0);
    vt[10] = mk(0,1,0,0,8'h03,0,0,32'h0000_0030,1,0);
    vt[11] = mk(0,0,1,0,8'h80,0,0,32'hFFFF_FE34,1,0);
    vt[12] = mk(0,0,1,0,8'h7F,0,0,32'h0000_0034,1,0);
    vt[13] = mk(0,0,0,0,8'h00,0,0,32'h0000_0038,1,0);
    vt[14] = mk(0,0,0,0,8'h00,0,0,32'h0000_003C,1,0);
    vt[15] = mk(0,0,0,0,8'h00,0,0,32'h0000_0040,1,0);
    vt[16] = mk(0,0,1,0,8'h05,1,0,32'h0000_0040,1,1);
    vt[17] = mk(0,0,0,0,8'h00,1,0,32'h0000_0040,1,2);
    vt[18] = mk(1,0,0,1,8'h10,1,1,32'h0000_0040,1,3);
    vt[19] = mk(0,0,0,0,8'h00,1,0,32'h0000_0040,1,4);
    vt[20] = mk(0,0,1,0,8'h10,0,0,32'h0000_0058,1,4);
    vt[21] = mk(0,1,0,1,8'h03,0,0,32'h0000_005C,1,4);
    vt[22] = mk(1,0,1,0,8'hFF,0,0,32'h0000_005C,1,4);
    vt[23] = mk(0,0,0,0,8'h00,1,1,32'h0000_005C,0,4);
    vt[24] = mk(0,0,1,0,8'h08,1,0,32'h0000_005C,0,4);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].br, vt[i].bne, vt[i].jmp, vt[i].zero,
            vt[i].off, vt[i].busy, vt[i].halt);
      step();
      chk_all($sformatf("v%0d", i), vt[i].pc, vt[i].iread,
              vt[i].cnt);
    end

    // Halt at 0x8, busy toggling ignored, reset exits.
    do_reset();
    repeat (3) step();
    chk_all("h.pre", 32'h8, 1'b1, 16'd0);
    drive(0, 0, 0, 0, 8'h00, 0, 1);
    step();
    chk_all("h.enter", 32'h8, 1'b0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 8'h10, k[0], 0);
      step();
      chk_all($sformatf("h.hold%0d", k), 32'h8, 1'b0, 16'd0);
    end
    RESET = 1'b0;
    #1;
    chk_all("h.rst", 32'h0, 1'b0, 16'd0);

    // Async reset mid-stall discards the captured target.
    do_reset();
    step();
    drive(0, 0, 1, 0, 8'h10, 1, 0);
    repeat (3) step();
    chk_all("s.stall", 32'h0, 1'b1, 16'd3);
    #2;
    RESET = 1'b0;
    #1;
    chk_all("s.rst", 32'h0, 1'b0, 16'd0);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    step();
    RESET = 1'b1;
    #1;
    chk_all("s.boot", 32'h0, 1'b0, 16'd0);
    step();
    chk_all("s.run", 32'h0, 1'b1, 16'd0);
    step();
    chk_all("s.fetch", 32'h4, 1'b1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
